// File: rtl/wb_pkg.sv
// Shared definitions for the write-back sequencer: MemtoReg codes, requester
// indices, FSM state type and the requester/sub-select to code mapping.
package wb_pkg;

  localparam int N_REQ = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    WRITE = 2'd2
  } state_t;

  // Requester indices, matching the bit positions of req_valid / req_ack.
  localparam logic [1:0] REQ_LOAD  = 2'd0;
  localparam logic [1:0] REQ_SHIFT = 2'd1;
  localparam logic [1:0] REQ_HILO  = 2'd2;
  localparam logic [1:0] REQ_ALU   = 2'd3;

  // MemtoReg write-back mux select codes; 1000-1011 are spare mux inputs.
  localparam logic [3:0] MTR_EXT_I  = 4'b0000;
  localparam logic [3:0] MTR_EXT_II = 4'b0001;
  localparam logic [3:0] MTR_WRITE  = 4'b0010;
  localparam logic [3:0] MTR_SHIFT  = 4'b0011;
  localparam logic [3:0] MTR_HI     = 4'b0100;
  localparam logic [3:0] MTR_LO     = 4'b0101;
  localparam logic [3:0] MTR_ALUOUT = 4'b0110;
  localparam logic [3:0] MTR_LT     = 4'b0111;
  localparam logic [3:0] MTR_AUX0   = 4'b1000;
  localparam logic [3:0] MTR_AUX1   = 4'b1001;
  localparam logic [3:0] MTR_AUX2   = 4'b1010;
  localparam logic [3:0] MTR_AUX3   = 4'b1011;

  typedef struct packed {
    logic [3:0] code;
    logic       invalid;
  } wb_map_t;

  // Unknown sub-selects fall back to the ALU output path with the strobe killed.
  function automatic wb_map_t map_code(input logic [1:0] req, input logic [1:0] sel);
    wb_map_t m;
    m.code    = MTR_ALUOUT;
    m.invalid = 1'b1;
    case (req)
      REQ_LOAD: begin
        if (sel != 2'd3) begin
          m.code    = (sel == 2'd0) ? MTR_EXT_I : (sel == 2'd1) ? MTR_EXT_II : MTR_WRITE;
          m.invalid = 1'b0;
        end
      end
      REQ_SHIFT: begin
        m.code    = MTR_SHIFT;
        m.invalid = 1'b0;
      end
      REQ_HILO: begin
        if (sel < 2'd2) begin
          m.code    = sel[0] ? MTR_LO : MTR_HI;
          m.invalid = 1'b0;
        end
      end
      default: begin
        if (sel < 2'd2) begin
          m.code    = sel[0] ? MTR_LT : MTR_ALUOUT;
          m.invalid = 1'b0;
        end
      end
    endcase
    return m;
  endfunction

  function automatic logic [1:0] onehot_to_idx(input logic [3:0] oh);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 0; i < N_REQ; i++) begin
      if (oh[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_arbiter4.sv
// Four-way round-robin arbiter: the first active request at or after ptr
// (wrapping) wins; grant is one-hot, or zero when nothing is requested.
module rr_arbiter4
  import wb_pkg::*;
(
  input  logic [3:0] req,
  input  logic [1:0] ptr,
  output logic [3:0] grant
);

  // Scan from the farthest offset down so the nearest one to ptr overwrites last.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path leaves it unassigned and no latch is inferred.
    grant = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req[ptr + 2'(i)]) begin
        grant                = '0;
        grant[ptr + 2'(i)]   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wb_sequencer.sv
// Write-back sequencer: arbitrates four requesters and drives the register-file
// write port through a three-state IDLE -> SETUP -> WRITE handshake.
module wb_sequencer
  import wb_pkg::*;
#(
  parameter bit ZERO_SUPPRESS = 1'b1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       flush,
  input  logic [3:0] req_valid,
  input  logic [1:0] req_sel0,
  input  logic [1:0] req_sel1,
  input  logic [1:0] req_sel2,
  input  logic [1:0] req_sel3,
  input  logic [4:0] req_rd0,
  input  logic [4:0] req_rd1,
  input  logic [4:0] req_rd2,
  input  logic [4:0] req_rd3,
  output logic [3:0] req_ack,
  output logic [3:0] MemtoReg,
  output logic [4:0] wb_rd,
  output logic       RegWrite,
  output logic       busy
);

  state_t     state_q, state_d;
  logic [1:0] ptr_q;
  logic [1:0] gnt_idx_q;
  logic       suppress_q;
  logic       grant_en;
  logic [3:0] grant;
  logic [1:0] grant_idx;
  logic [1:0] sel_g;
  logic [4:0] rd_g;
  wb_map_t    map_g;

  rr_arbiter4 u_arb (
    .req   (req_valid),
    .ptr   (ptr_q),
    .grant (grant)
  );

  assign grant_idx = onehot_to_idx(grant);

  always_comb begin
    sel_g = req_sel0;
    rd_g  = req_rd0;
    case (grant_idx)
      REQ_SHIFT: begin sel_g = req_sel1; rd_g = req_rd1; end
      REQ_HILO:  begin sel_g = req_sel2; rd_g = req_rd2; end
      REQ_ALU:   begin sel_g = req_sel3; rd_g = req_rd3; end
      default:   begin sel_g = req_sel0; rd_g = req_rd0; end
    endcase
  end

  assign map_g = map_code(grant_idx, sel_g);

  always_comb begin
    state_d  = state_q;
    grant_en = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!flush && (|req_valid)) begin
          grant_en = 1'b1;
          state_d  = SETUP;
        end
      end
      SETUP:   state_d = flush ? IDLE : WRITE;
      WRITE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Requester inputs are captured only on the grant cycle; the write then runs
  // from the latched copy, so requesters may change them freely afterwards.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      gnt_idx_q  <= '0;
      suppress_q <= 1'b0;
      MemtoReg   <= MTR_ALUOUT;
      wb_rd      <= '0;
    end else begin
      // NOTE: non-blocking assignments here so every register samples pre-edge values regardless of statement order.
      state_q <= state_d;
      if (grant_en) begin
        gnt_idx_q  <= grant_idx;
        MemtoReg   <= map_g.code;
        wb_rd      <= rd_g;
        suppress_q <= map_g.invalid || (ZERO_SUPPRESS && (rd_g == 5'd0));
      end
      // A flushed SETUP never reaches WRITE, so the pointer only moves on completion.
      if (state_q == WRITE) begin
        ptr_q <= gnt_idx_q + 2'd1;
      end
    end
  end

  assign busy     = (state_q != IDLE);
  assign RegWrite = (state_q == WRITE) && !suppress_q;
  assign req_ack  = (state_q == WRITE) ? (4'b0001 << gnt_idx_q) : 4'b0000;

endmodule

// File: doc/wb_sequencer.md
WB_SEQUENCER -- requirements
Module: wb_sequencer

Interface
REQ-001 The block SHALL have parameter ZERO_SUPPRESS, default 1: when 1, writes to register 0 are acknowledged but never strobed.
REQ-002 The block SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset_n, input, 1: asynchronous, active-low reset.
REQ-004 The block SHALL have port flush, input, 1: synchronous abort of a not-yet-strobed write.
REQ-005 The block SHALL have ports req_valid[3:0], input, 4: write-back requests; bit 0 load, bit 1 shift, bit 2 hi/lo, bit 3 ALU.
REQ-006 The block SHALL have ports req_sel0..req_sel3, input, 2 each: sub-select per requester (load: 0 ExtI, 1 ExtII, 2 Write; hi/lo: 0 hi, 1 lo; ALU: 0 ALUOut, 1 lt; shift: ignored).
REQ-007 The block SHALL have ports req_rd0..req_rd3, input, 5 each: destination register per requester.
REQ-008 The block SHALL have port req_ack, output, 4: one-hot, one-cycle acknowledge of a completed request.
REQ-009 The block SHALL have port MemtoReg, output, 4: write-back mux select code.
REQ-010 The block SHALL have port wb_rd, output, 5: register-file write address.
REQ-011 The block SHALL have port RegWrite, output, 1: register-file write strobe.
REQ-012 The block SHALL have port busy, output, 1: high in any state other than IDLE.

Function
REQ-013 The FSM SHALL have states IDLE, SETUP, WRITE.
REQ-014 IDLE: if any req_valid is high, the arbiter SHALL grant one requester, latch its code and rd into MemtoReg/wb_rd, and go to SETUP; otherwise it SHALL stay in IDLE.
REQ-015 Arbitration SHALL be round-robin; the pointer SHALL advance to (granted+1) mod 4 only when the request completes in WRITE.
REQ-016 The code mapping SHALL be: load sel 0/1/2 -> 0000/0001/0010; shift -> 0011; hi/lo sel 0/1 -> 0100/0101; ALU sel 0/1 -> 0110/0111; load sel 3 and hi/lo or ALU sel 2-3 -> 0110 with RegWrite suppressed.
REQ-017 SETUP SHALL last exactly one cycle with MemtoReg and wb_rd stable and RegWrite=0, then go to WRITE.
REQ-018 WRITE SHALL last exactly one cycle: RegWrite=1 (unless suppressed), req_ack bit of the granted requester =1; next state IDLE.
REQ-019 RegWrite SHALL be suppressed when wb_rd=0 and ZERO_SUPPRESS=1, or when the sub-select is invalid; req_ack SHALL still pulse.
REQ-020 Latency SHALL be 2 cycles from grant to strobe; peak throughput one write per 3 cycles.
REQ-021 A requester SHALL hold req_valid, req_sel and req_rd until it sees its req_ack; a valid dropped before grant SHALL be ignored without ack.
REQ-022 Requester inputs SHALL be sampled only at grant; changes after grant SHALL not affect the write in progress.
REQ-023 flush in IDLE SHALL block granting that cycle; flush in SETUP SHALL return to IDLE with no strobe, no ack, and pointer unchanged; flush in WRITE SHALL be ignored (write completes).
REQ-024 MemtoReg and wb_rd SHALL hold their last value in IDLE.
REQ-025 req_ack SHALL be zero in every cycle except WRITE.

Reset
REQ-026 On reset_n low, the block SHALL asynchronously enter IDLE with MemtoReg=0110, wb_rd=0, RegWrite=0, req_ack=0, busy=0, pointer=0.
REQ-027 Reset during SETUP or WRITE SHALL abort the write with no strobe and no ack after reset.

Structure
REQ-028 A shared package wb_pkg SHALL hold the MemtoReg code constants (0000-1011), the requester index constants, and the FSM state type.
REQ-029 Arbitration SHALL be a sub-module rr_arbiter4 (4 requests, pointer in, one-hot grant out); code mapping and FSM SHALL be in wb_sequencer.

Verification
REQ-030 Single ALU request: req_valid=1000, sel3=1, rd3=8 -> MemtoReg=0111, wb_rd=8 in SETUP; RegWrite=1 and req_ack=1000 the next cycle.
REQ-031 All four valid from reset, held until ack -> grants in order load, shift, hi/lo, ALU; acks 0001, 0010, 0100, 1000 at 3-cycle spacing.
REQ-032 Load with rd0=0, ZERO_SUPPRESS=1 -> req_ack=0001 pulses, RegWrite stays 0 throughout.
REQ-033 hi/lo sel2=1, rd2=5, flush high in SETUP -> no RegWrite, no ack, IDLE next; re-grant of requester 2 follows with MemtoReg=0101.
REQ-034 reset_n low mid-WRITE -> RegWrite and req_ack drop immediately; outputs equal REQ-026 values.
REQ-035 ALU sel3=2, rd3=9 -> MemtoReg=0110, RegWrite=0, req_ack=1000.
